// File: rtl/led_arbiter.sv
// led_arbiter: shares the 4-bit LED bank between three requesters, with a minimum-hold guard.
//   Requester 0 has the highest priority. A display-tick prescaler paces blink and chase.
// Latency: a grant lands one cycle after REQ is sampled. Release takes one cycle and leaves
//   exactly one idle cycle. Preemption switches owners directly, with no idle cycle.
// Backpressure: none. REQ is a level request, and a requester keeps it high while it waits.
// Ports: CLK, RST (async, active high), REQ[2:0], MODEn[1:0]/PATn[3:0] per requester,
//   GNT[2:0] (one-hot or zero), LED[3:0], TICK (one-cycle strobe), BUSY (= |GNT).
module led_arbiter #(
  parameter int         TICK_DIV = 25_000_000,
  parameter int         MIN_HOLD = 2,
  parameter logic [3:0] IDLE_PAT = 4'b0000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic [1:0] MODE0,
  input  logic [1:0] MODE1,
  input  logic [1:0] MODE2,
  input  logic [3:0] PAT0,
  input  logic [3:0] PAT1,
  input  logic [3:0] PAT2,
  output logic [2:0] GNT,
  output logic [3:0] LED,
  output logic       TICK,
  output logic       BUSY
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pre_cnt;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [2:0]    gnt, gnt_nx;
  logic [3:0]    led, led_nx;
  logic [1:0]    lmode, lmode_nx;
  logic [3:0]    lpat, lpat_nx;

  logic [2:0]    higher;
  logic          owner_req;
  logic [2:0]    cand;
  logic [2:0]    new_gnt;
  logic [1:0]    new_mode;
  logic [3:0]    new_pat;
  logic [3:0]    anim;

  // The prescaler free-runs regardless of grant state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign TICK = (pre_cnt == PRE_LAST);

  // gnt is one-hot, so gnt-1 masks exactly the bits that have a higher priority than the owner.
  assign higher    = REQ & (gnt - 3'd1);
  assign owner_req = |(REQ & gnt);
  assign cand      = (state == S_IDLE) ? REQ : higher;
  // Isolate the lowest set bit, which is the highest-priority candidate.
  assign new_gnt   = cand & (~cand + 3'd1);

  always_comb begin
    new_mode = 2'b00;
    new_pat  = 4'b0000;
    case (new_gnt)
      3'b001:  begin new_mode = MODE0; new_pat = PAT0; end
      3'b010:  begin new_mode = MODE1; new_pat = PAT1; end
      3'b100:  begin new_mode = MODE2; new_pat = PAT2; end
      default: begin new_mode = 2'b00; new_pat = 4'b0000; end
    endcase
  end

  // Mode 11 is reserved and behaves like static.
  always_comb begin
    anim = led;
    case (lmode)
      2'b01:   anim = led ^ lpat;
      2'b10:   anim = {led[2:0], led[3]};
      default: anim = led;
    endcase
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    gnt_nx   = gnt;
    led_nx   = led;
    lmode_nx = lmode;
    lpat_nx  = lpat;
    case (state)
      S_IDLE: begin
        if (|REQ) begin
          state_nx = S_OWN;
          gnt_nx   = new_gnt;
          lmode_nx = new_mode;
          lpat_nx  = new_pat;
          led_nx   = new_pat;
          hold_nx  = '0;
        end else begin
          led_nx = IDLE_PAT;
        end
      end
      S_OWN: begin
        // Release beats preemption, and both beat the tick animation.
        if (!owner_req) begin
          state_nx = S_IDLE;
          gnt_nx   = 3'b000;
          led_nx   = IDLE_PAT;
        end else if ((|higher) && (hold_cnt >= HOLD_MAX)) begin
          gnt_nx   = new_gnt;
          lmode_nx = new_mode;
          lpat_nx  = new_pat;
          led_nx   = new_pat;
          hold_nx  = '0;
        end else if (TICK) begin
          if (hold_cnt != HOLD_MAX) begin
            hold_nx = hold_cnt + HW'(1);
          end
          led_nx = anim;
        end
      end
      default: begin
        state_nx = S_IDLE;
        gnt_nx   = 3'b000;
        led_nx   = IDLE_PAT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      gnt      <= 3'b000;
      led      <= IDLE_PAT;
      lmode    <= 2'b00;
      lpat     <= 4'b0000;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      gnt      <= gnt_nx;
      led      <= led_nx;
      lmode    <= lmode_nx;
      lpat     <= lpat_nx;
    end
  end

  assign GNT  = gnt;
  assign LED  = led;
  assign BUSY = |gnt;

endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares the 4-bit board LED bank between three requesters: REQ[0] error, REQ[1] status, REQ[2] heartbeat.
- Fixed-priority arbitration with a minimum-hold guard. Each requester supplies its own pattern and display mode.
- An internal prescaler generates the display tick that paces blink and chase animation.
- Sits between system status logic and the LED pins. It replaces free-running LED drivers in the top level.

Parameters:
- TICK_DIV, 25_000_000: CLK cycles per display tick (1 s at 25 MHz); legal values ≥ 2.
- MIN_HOLD, 2: ticks an owner keeps the LEDs before a higher-priority requester may preempt it.
- IDLE_PAT, 4'b0000: LED value when no requester owns the bank.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  3  request per requester; REQ[0] has highest priority. A requester holds REQ high while it wants the LEDs.
- MODE0, MODE1, MODE2  in  2 each  display mode per requester: 00 static, 01 blink, 10 chase, 11 reserved (treated as static).
- PAT0, PAT1, PAT2  in  4 each  pattern per requester.
- GNT  out  3  one-hot grant, or all zero.
- LED  out  4  LED drive.
- TICK  out  1  one-cycle display-tick strobe.
- BUSY  out  1  high while any grant is active.

Behaviour:
- Reset (async, RST=1):
  - prescaler=0, TICK=0, GNT=0, LED=IDLE_PAT, BUSY=0.
  - hold_cnt=0, FSM=IDLE, latched mode/pattern cleared.
  - All registers release on the first CLK edge after RST falls.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - TICK=1 for exactly the cycle in which the count equals TICK_DIV-1; first TICK occurs TICK_DIV cycles after reset release.
  - Free-runs independent of grant state.
- FSM states: IDLE, OWN.
- IDLE:
  - If REQ≠0, on the next edge:
    - GNT = one-hot of the lowest-indexed set REQ bit.
    - Latch that requester's MODE/PAT.
    - LED <= latched PAT; hold_cnt <= 0; BUSY <= 1; go to OWN.
  - Grant latency is one cycle from REQ sampled high.
  - If REQ=0: stay in IDLE with LED=IDLE_PAT.
- OWN, evaluated each edge in this priority order:
  1. Owner's REQ bit low:
     - GNT <= 0, LED <= IDLE_PAT, BUSY <= 0, go to IDLE.
     - Other pending requests are arbitrated on the following cycle (exactly one idle cycle).
  2. A higher-priority REQ bit is high and hold_cnt ≥ MIN_HOLD: preempt.
     - Grant it directly (no idle cycle) and latch its MODE/PAT.
     - LED <= new PAT, hold_cnt <= 0, stay in OWN.
  3. TICK=1:
     - hold_cnt increments, saturating at MIN_HOLD.
     - LED update by latched mode: static → unchanged; blink → LED <= LED ^ latched PAT (alternates PAT / 0000); chase → LED <= {LED[2:0], LED[3]}.
  4. Otherwise hold.
- Equal- or lower-priority requests never preempt. They wait until the owner releases.
- MODE/PAT changes while owned are ignored. New values take effect only on a new grant, including a re-grant to the same requester after release.
- Simultaneous events:
  - A grant or preemption in a TICK cycle takes precedence: no animation step and no hold increment that cycle.
  - Release in a TICK cycle: release wins.
- Edge cases:
  - Chase with PAT=0000 stays 0000.
  - Blink with PAT=0000 stays 0000.
  - MIN_HOLD=0 permits preemption on the cycle after any grant.
- Widths: hold_cnt is clog2(MIN_HOLD+1) bits (minimum 1). The prescaler is clog2(TICK_DIV) bits.
- GNT is always one-hot or zero. BUSY equals |GNT.

Test Plan (TICK_DIV=4, MIN_HOLD=2):
1. Reset and idle: assert RST mid-run while owning, then release. Required: LED=0000, GNT=000, BUSY=0 immediately on RST assertion; TICK first pulses 4 cycles after release and every 4 cycles thereafter.
2. Chase: REQ=100, MODE2=10, PAT2=0001. Required: GNT=100 and LED=0001 one cycle later; LED steps 0010, 0100, 1000, 0001 on successive TICKs.
3. Blink and release: REQ=010, MODE1=01, PAT1=1010. Required: LED alternates 1010/0000 per TICK. On REQ→000: GNT=000 and LED=0000 the next cycle.
4. Preemption guard: requester 2 owns; REQ[0] rises one tick after the grant, with PAT0=1111 static. Required: no switch until hold_cnt reaches 2 (second TICK after the grant); then GNT=001, LED=1111 the next cycle with no idle gap.
5. No lower-priority preemption: requester 0 owns, REQ[2] high for 10 ticks. Required: GNT stays 001. When REQ[0] drops: one cycle of GNT=000, then GNT=100.
6. Latch isolation and simultaneity: change PAT1 while requester 1 owns. Required: LED unaffected. Grant landing on a TICK cycle: LED=PAT, no chase step that cycle.
